// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - in-order register write-back FIFO with same-cycle read bypass
module writeback_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_address,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       rf_write_ready,
  output logic                       rf_write_enabled,
  output logic [ADDR_WIDTH-1:0]      rf_write_address,
  output logic [DATA_WIDTH-1:0]      rf_write_data,
  input  logic [ADDR_WIDTH-1:0]      lookup_address_1,
  output logic                       lookup_hit_1,
  output logic [DATA_WIDTH-1:0]      lookup_data_1,
  input  logic [ADDR_WIDTH-1:0]      lookup_address_2,
  output logic                       lookup_hit_2,
  output logic [DATA_WIDTH-1:0]      lookup_data_2,
  output logic [$clog2(DEPTH):0]     pending_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;

  // Readiness depends only on registered count, so a full queue refuses
  // even when the head is being drained in the same cycle.
  assign in_ready         = (count != CNT_W'(DEPTH));
  assign push             = in_valid && in_ready && (in_address != '0);
  assign rf_write_enabled = (count != '0);
  assign pop              = rf_write_enabled && rf_write_ready;

  assign rf_write_address = addr_mem[head];
  assign rf_write_data    = data_mem[head];
  assign pending_count    = count;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && push) begin
      addr_mem[tail] <= in_address;
      data_mem[tail] <= in_data;
    end
  end

  // Slot g is the g-th oldest pending entry; valid while g < count.
  logic [PTR_W-1:0] slot_idx   [DEPTH];
  logic             slot_valid [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    assign slot_idx[g]   = head + PTR_W'(g);
    assign slot_valid[g] = (CNT_W'(g) < count);
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit_1  = 1'b0;
    lookup_data_1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (lookup_address_1 != '0) &&
          (addr_mem[slot_idx[i]] == lookup_address_1)) begin
        lookup_hit_1  = 1'b1;
        lookup_data_1 = data_mem[slot_idx[i]];
      end
    end
  end

  always_comb begin
    lookup_hit_2  = 1'b0;
    lookup_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (lookup_address_2 != '0) &&
          (addr_mem[slot_idx[i]] == lookup_address_2)) begin
        lookup_hit_2  = 1'b1;
        lookup_data_2 = data_mem[slot_idx[i]];
      end
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed and randomized checks of writeback_queue against a queue model
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 3;

  typedef logic [AW+DW-1:0] ent_t;

  logic          clock = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_address;
  logic [DW-1:0] in_data;
  logic          rf_write_ready;
  logic          rf_write_enabled;
  logic [AW-1:0] rf_write_address;
  logic [DW-1:0] rf_write_data;
  logic [AW-1:0] lookup_address_1;
  logic          lookup_hit_1;
  logic [DW-1:0] lookup_data_1;
  logic [AW-1:0] lookup_address_2;
  logic          lookup_hit_2;
  logic [DW-1:0] lookup_data_2;
  logic [CW-1:0] pending_count;

  writeback_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_address       (in_address),
    .in_data          (in_data),
    .rf_write_ready   (rf_write_ready),
    .rf_write_enabled (rf_write_enabled),
    .rf_write_address (rf_write_address),
    .rf_write_data    (rf_write_data),
    .lookup_address_1 (lookup_address_1),
    .lookup_hit_1     (lookup_hit_1),
    .lookup_data_1    (lookup_data_1),
    .lookup_address_2 (lookup_address_2),
    .lookup_hit_2     (lookup_hit_2),
    .lookup_data_2    (lookup_data_2),
    .pending_count    (pending_count)
  );

  always #5 clock = ~clock;

  ent_t mq[$];
  ent_t exp_writes[$];
  ent_t act_writes[$];
  int   nv = 0;
  int   nm = 0;

  function automatic void model_lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i][AW+DW-1:DW] == a) begin
          h = 1'b1;
          d = mq[i][DW-1:0];
          break;
        end
      end
    end
  endfunction

  // Called just before a posedge with inputs stable: logs the DUT's write and advances the model.
  task automatic tick();
    logic p_pop;
    logic p_push;
    if (resetn && rf_write_enabled && rf_write_ready)
      act_writes.push_back({rf_write_address, rf_write_data});
    if (!resetn) begin
      mq.delete();
    end else begin
      p_pop  = (mq.size() != 0) && rf_write_ready;
      p_push = in_valid && (mq.size() != DEPTH) && (in_address != '0);
      if (p_pop) begin
        exp_writes.push_back(mq[0]);
        void'(mq.pop_front());
      end
      if (p_push) mq.push_back({in_address, in_data});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1; in_address = a; in_data = d;
    #4;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_address = '0; in_data = '0; rf_write_ready = 1'b0;
    lookup_address_1 = 5'd3; lookup_address_2 = 5'd0;
    tick(); tick();
    resetn = 1'b1;
    #4;
    nv++; if (in_ready !== 1'b1) begin nm++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    nv++; if (rf_write_enabled !== 1'b0) begin nm++; $display("FAIL reset_rf_en: got %b exp 0", rf_write_enabled); end
    nv++; if (pending_count !== 3'd0) begin nm++; $display("FAIL reset_count: got %0d exp 0", pending_count); end
    nv++; if (lookup_hit_1 !== 1'b0) begin nm++; $display("FAIL reset_hit: got %b exp 0", lookup_hit_1); end
    tick();
  endtask

  task automatic test_single();
    rf_write_ready = 1'b1;
    in_valid = 1'b1; in_address = 5'd3; in_data = 32'h11111111;
    #4;
    nv++; if (rf_write_enabled !== 1'b0) begin nm++; $display("FAIL single_no_early_write: got %b exp 0", rf_write_enabled); end
    tick();
    in_valid = 1'b0;
    #4;
    nv++; if (rf_write_enabled !== 1'b1) begin nm++; $display("FAIL single_rf_en: got %b exp 1", rf_write_enabled); end
    nv++; if (rf_write_address !== 5'd3) begin nm++; $display("FAIL single_addr: got %0d exp 3", rf_write_address); end
    nv++; if (rf_write_data !== 32'h11111111) begin nm++; $display("FAIL single_data: got %h exp 11111111", rf_write_data); end
    tick();
    #4;
    nv++; if (pending_count !== 3'd0) begin nm++; $display("FAIL single_drained: got %0d exp 0", pending_count); end
    nv++; if (rf_write_enabled !== 1'b0) begin nm++; $display("FAIL single_rf_idle: got %b exp 0", rf_write_enabled); end
    tick();
  endtask

  task automatic test_full();
    logic [AW-1:0] ea [5];
    logic [DW-1:0] ed [5];
    ea = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
    ed = '{32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    act_writes.delete();
    rf_write_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_address = ea[i]; in_data = ed[i];
      #4;
      nv++; if (in_ready !== 1'b1) begin nm++; $display("FAIL full_fill_ready[%0d]: got %b exp 1", i, in_ready); end
      tick();
    end
    in_address = ea[4]; in_data = ed[4];
    #4;
    nv++; if (in_ready !== 1'b0) begin nm++; $display("FAIL full_in_ready: got %b exp 0", in_ready); end
    nv++; if (pending_count !== 3'd4) begin nm++; $display("FAIL full_count: got %0d exp 4", pending_count); end
    tick();
    rf_write_ready = 1'b1;
    #4;
    nv++; if (in_ready !== 1'b0) begin nm++; $display("FAIL full_refuse_on_pop: got %b exp 0", in_ready); end
    nv++; if (pending_count !== 3'd4) begin nm++; $display("FAIL full_held: got %0d exp 4", pending_count); end
    tick();
    #4;
    nv++; if (in_ready !== 1'b1) begin nm++; $display("FAIL full_ready_after_pop: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #4;
      tick();
    end
    nv++; if (act_writes.size() !== 5) begin nm++; $display("FAIL full_write_count: got %0d exp 5", act_writes.size()); end
    for (int i = 0; i < 5 && i < act_writes.size(); i++) begin
      nv++;
      if (act_writes[i] !== {ea[i], ed[i]}) begin
        nm++; $display("FAIL full_order[%0d]: got %h exp %h", i, act_writes[i], {ea[i], ed[i]});
      end
    end
  endtask

  task automatic test_bypass();
    rf_write_ready = 1'b0;
    push_one(5'd5, 32'hAA);
    push_one(5'd5, 32'hBB);
    lookup_address_1 = 5'd5; lookup_address_2 = 5'd6;
    #4;
    nv++; if (lookup_hit_1 !== 1'b1) begin nm++; $display("FAIL bypass_hit1: got %b exp 1", lookup_hit_1); end
    nv++; if (lookup_data_1 !== 32'hBB) begin nm++; $display("FAIL bypass_youngest: got %h exp bb", lookup_data_1); end
    nv++; if (lookup_hit_2 !== 1'b0) begin nm++; $display("FAIL bypass_hit2: got %b exp 0", lookup_hit_2); end
    nv++; if (lookup_data_2 !== 32'h0) begin nm++; $display("FAIL bypass_data2: got %h exp 0", lookup_data_2); end
    rf_write_ready = 1'b1;
    tick();
    #4;
    nv++; if (lookup_hit_1 !== 1'b1 || lookup_data_1 !== 32'hBB) begin
      nm++; $display("FAIL bypass_popping_entry: got hit %b data %h exp hit 1 data bb", lookup_hit_1, lookup_data_1);
    end
    tick();
    #4;
    nv++; if (lookup_hit_1 !== 1'b0 || lookup_data_1 !== 32'h0) begin
      nm++; $display("FAIL bypass_after_drain: got hit %b data %h exp hit 0 data 0", lookup_hit_1, lookup_data_1);
    end
    tick();
  endtask

  task automatic test_addr0();
    rf_write_ready = 1'b1;
    lookup_address_1 = 5'd0;
    in_valid = 1'b1; in_address = 5'd0; in_data = 32'hDEAD;
    #4;
    nv++; if (in_ready !== 1'b1) begin nm++; $display("FAIL addr0_handshake: got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #4;
    nv++; if (pending_count !== 3'd0) begin nm++; $display("FAIL addr0_count: got %0d exp 0", pending_count); end
    nv++; if (rf_write_enabled !== 1'b0) begin nm++; $display("FAIL addr0_no_write: got %b exp 0", rf_write_enabled); end
    nv++; if (lookup_hit_1 !== 1'b0) begin nm++; $display("FAIL addr0_lookup: got %b exp 0", lookup_hit_1); end
    tick();
  endtask

  task automatic test_steady();
    act_writes.delete(); exp_writes.delete();
    rf_write_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(AW'($urandom_range(1, 31)), $urandom);
    rf_write_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_address = AW'($urandom_range(1, 31)); in_data = $urandom;
      #4;
      nv++; if (pending_count !== 3'd3) begin nm++; $display("FAIL steady_count[%0d]: got %0d exp 3", i, pending_count); end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin #4; tick(); end
    nv++; if (act_writes.size() !== 13 || exp_writes.size() !== 13) begin
      nm++; $display("FAIL steady_write_count: got %0d exp 13", act_writes.size());
    end
    for (int i = 0; i < act_writes.size() && i < exp_writes.size(); i++) begin
      nv++; if (act_writes[i] !== exp_writes[i]) begin
        nm++; $display("FAIL steady_order[%0d]: got %h exp %h", i, act_writes[i], exp_writes[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rf_write_ready = 1'b0;
    push_one(5'd7, 32'h77);
    push_one(5'd8, 32'h88);
    #4;
    nv++; if (pending_count !== 3'd2) begin nm++; $display("FAIL rmid_pre_count: got %0d exp 2", pending_count); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    lookup_address_1 = 5'd7; lookup_address_2 = 5'd8;
    #4;
    nv++; if (pending_count !== 3'd0) begin nm++; $display("FAIL rmid_count: got %0d exp 0", pending_count); end
    nv++; if (rf_write_enabled !== 1'b0) begin nm++; $display("FAIL rmid_rf_en: got %b exp 0", rf_write_enabled); end
    nv++; if (in_ready !== 1'b1) begin nm++; $display("FAIL rmid_in_ready: got %b exp 1", in_ready); end
    nv++; if (lookup_hit_1 !== 1'b0 || lookup_hit_2 !== 1'b0) begin
      nm++; $display("FAIL rmid_lookup: got %b%b exp 00", lookup_hit_1, lookup_hit_2);
    end
    tick();
  endtask

  task automatic test_random();
    logic          h;
    logic [DW-1:0] d;
    act_writes.delete(); exp_writes.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid         = ($urandom_range(0, 3) != 0);
      in_address       = AW'($urandom_range(0, 7));
      in_data          = $urandom;
      rf_write_ready   = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      lookup_address_1 = AW'($urandom_range(0, 7));
      lookup_address_2 = AW'($urandom_range(0, 7));
      #4;
      nv++; if (in_ready !== (mq.size() != DEPTH)) begin nm++; $display("FAIL rnd_in_ready[%0d]: got %b exp %b", c, in_ready, mq.size() != DEPTH); end
      nv++; if (pending_count !== CW'(mq.size())) begin nm++; $display("FAIL rnd_count[%0d]: got %0d exp %0d", c, pending_count, mq.size()); end
      nv++; if (rf_write_enabled !== (mq.size() != 0)) begin nm++; $display("FAIL rnd_rf_en[%0d]: got %b exp %b", c, rf_write_enabled, mq.size() != 0); end
      if (mq.size() != 0) begin
        nv++; if ({rf_write_address, rf_write_data} !== mq[0]) begin
          nm++; $display("FAIL rnd_head[%0d]: got %h exp %h", c, {rf_write_address, rf_write_data}, mq[0]);
        end
      end
      model_lookup(lookup_address_1, h, d);
      nv++; if (lookup_hit_1 !== h || lookup_data_1 !== d) begin
        nm++; $display("FAIL rnd_lookup1[%0d]: got %b/%h exp %b/%h", c, lookup_hit_1, lookup_data_1, h, d);
      end
      model_lookup(lookup_address_2, h, d);
      nv++; if (lookup_hit_2 !== h || lookup_data_2 !== d) begin
        nm++; $display("FAIL rnd_lookup2[%0d]: got %b/%h exp %b/%h", c, lookup_hit_2, lookup_data_2, h, d);
      end
      tick();
    end
    nv++; if (act_writes.size() !== exp_writes.size()) begin
      nm++; $display("FAIL rnd_write_count: got %0d exp %0d", act_writes.size(), exp_writes.size());
    end
    for (int i = 0; i < act_writes.size() && i < exp_writes.size(); i++) begin
      nv++; if (act_writes[i] !== exp_writes[i]) begin
        nm++; $display("FAIL rnd_order[%0d]: got %h exp %h", i, act_writes[i], exp_writes[i]);
      end
    end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_address = '0; in_data = '0; rf_write_ready = 1'b0;
    lookup_address_1 = '0; lookup_address_2 = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_single();
    test_full();
    test_bypass();
    test_addr0();
    test_steady();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, nm);
    $finish;
  end

endmodule
